// File: rtl/period_capture_if.sv
// Purpose: bundles the control, pulse and result signals of period_capture.
// Latency: n/a (wires only).
// Backpressure: result is held while period_valid && !period_ready.
// Ports: master = controller/consumer side, slave = period_capture side.
//   arm, timeout_val, pulse_in, period_ready : master -> slave
//   period_out, period_valid, overrun, timeout, busy : slave -> master
interface period_capture_if;
   logic        arm;
   logic [31:0] timeout_val;
   logic        pulse_in;
   logic [31:0] period_out;
   logic        period_valid;
   logic        period_ready;
   logic        overrun;
   logic        timeout;
   logic        busy;

   modport master (
      output arm, timeout_val, pulse_in, period_ready,
      input  period_out, period_valid, overrun, timeout, busy
   );

   modport slave (
      input  arm, timeout_val, pulse_in, period_ready,
      output period_out, period_valid, overrun, timeout, busy
   );
endinterface

// File: rtl/period_capture.sv
// Purpose: measures the rising-edge-to-rising-edge period of pulse_in in clk cycles.
// Latency: a result appears on the clock edge that samples the closing rising edge.
// Backpressure: result held until period_ready; a capture while still pending is dropped and flags overrun.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   bus      : period_capture_if.slave (arm, timeout_val, pulse_in, period_ready in;
//              period_out, period_valid, overrun, timeout, busy out)
module period_capture (
   input logic             clk,
   input logic             rst,
   period_capture_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_FIRST = 2'd1,
      MEASURE    = 2'd2
   } state_t;

   state_t      state_q;
   logic [31:0] cnt_q;
   logic        prev_q;
   logic [31:0] tmo_q;
   logic [31:0] period_out_q;
   logic        period_valid_q;
   logic        overrun_q;
   logic        timeout_q;
   logic        busy_q;

   logic        rise_det;
   logic        hs;
   logic [31:0] cnt_inc_d;

   assign rise_det  = bus.pulse_in & ~prev_q;
   assign hs        = period_valid_q & bus.period_ready;
   // Counter sticks at all-ones instead of wrapping to a misleading small period.
   assign cnt_inc_d = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         cnt_q          <= 32'd0;
         prev_q         <= 1'b0;
         tmo_q          <= 32'd0;
         period_out_q   <= 32'd0;
         period_valid_q <= 1'b0;
         overrun_q      <= 1'b0;
         timeout_q      <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         // Edge history tracks pulse_in in every state so a level already high
         // at arm time is not mistaken for a fresh edge later.
         prev_q <= bus.pulse_in;

         if (bus.arm) begin
            // arm overrides everything, including an edge in the same cycle.
            state_q        <= WAIT_FIRST;
            tmo_q          <= bus.timeout_val;
            cnt_q          <= 32'd0;
            timeout_q      <= 1'b0;
            overrun_q      <= 1'b0;
            period_valid_q <= 1'b0;
            busy_q         <= 1'b1;
         end else begin
            if (hs) begin
               period_valid_q <= 1'b0;
            end

            case (state_q)
               IDLE: begin
                  // Edges are ignored until armed.
               end

               WAIT_FIRST: begin
                  if (rise_det) begin
                     state_q <= MEASURE;
                     cnt_q   <= 32'd1;
                  end
               end

               MEASURE: begin
                  if (rise_det) begin
                     cnt_q <= 32'd1;
                     // Slot is free if empty or being drained this very cycle.
                     if (!period_valid_q || bus.period_ready) begin
                        period_out_q   <= cnt_q;
                        period_valid_q <= 1'b1;
                     end else begin
                        overrun_q <= 1'b1;
                     end
                  end else if ((tmo_q != 32'd0) && (cnt_q == tmo_q)) begin
                     timeout_q <= 1'b1;
                     state_q   <= WAIT_FIRST;
                     cnt_q     <= 32'd0;
                  end else begin
                     cnt_q <= cnt_inc_d;
                  end
               end

               default: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.period_out   = period_out_q;
   assign bus.period_valid = period_valid_q;
   assign bus.overrun      = overrun_q;
   assign bus.timeout      = timeout_q;
   assign bus.busy         = busy_q;

endmodule

// File: tb/tb_period_capture.sv
// Purpose: directed, table-driven bench for period_capture.
// Latency: each vector is applied before a rising edge and checked 1 time unit after it.
// Backpressure: period_ready is driven per vector to exercise hold, drain and overrun.
module tb_period_capture;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   period_capture_if bus_if ();

   period_capture dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   typedef struct {
      logic        rst;
      logic        arm;
      logic [31:0] tv;
      logic        pin;
      logic        rdy;
      logic [31:0] po;
      logic        pv;
      logic        ov;
      logic        to;
      logic        bz;
   } vec_t;

   vec_t vecs[$];
   int   total = 0;
   int   bad   = 0;

   task automatic add(input logic r, input logic a, input logic [31:0] tv,
                      input logic p, input logic rd,
                      input logic [31:0] po, input logic pv, input logic ov,
                      input logic to, input logic bz);
      vec_t v;
      v.rst = r;  v.arm = a;  v.tv = tv;  v.pin = p;  v.rdy = rd;
      v.po  = po; v.pv  = pv; v.ov = ov;  v.to  = to; v.bz  = bz;
      vecs.push_back(v);
   endtask

   task automatic step(input logic r, input logic a, input logic [31:0] tv,
                       input logic p, input logic rd);
      @(negedge clk);
      rst                 = r;
      bus_if.arm          = a;
      bus_if.timeout_val  = tv;
      bus_if.pulse_in     = p;
      bus_if.period_ready = rd;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string nm, input logic [31:0] po, input logic pv,
                          input logic ov, input logic to, input logic bz);
      chk({nm, ".period_out"},   bus_if.period_out,   po);
      chk({nm, ".period_valid"}, bus_if.period_valid, pv);
      chk({nm, ".overrun"},      bus_if.overrun,      ov);
      chk({nm, ".timeout"},      bus_if.timeout,      to);
      chk({nm, ".busy"},         bus_if.busy,         bz);
   endtask

   initial begin
      rst                 = 1'b1;
      bus_if.arm          = 1'b0;
      bus_if.timeout_val  = 32'd0;
      bus_if.pulse_in     = 1'b0;
      bus_if.period_ready = 1'b0;

      // ---- reset (arm must lose to rst), then pulses every 3 cycles unarmed ----
      add(1,1,5,1,0, 0,0,0,0,0);
      add(1,0,0,0,0, 0,0,0,0,0);
      add(0,0,0,1,1, 0,0,0,0,0);
      add(0,0,0,0,1, 0,0,0,0,0);
      add(0,0,0,0,1, 0,0,0,0,0);
      add(0,0,0,1,1, 0,0,0,0,0);
      add(0,0,0,0,1, 0,0,0,0,0);
      add(0,0,0,0,1, 0,0,0,0,0);
      add(0,0,0,1,1, 0,0,0,0,0);

      // ---- arm, no timeout, pulse every 7, consumer always ready ----
      add(0,1,0,0,1, 0,0,0,0,1);
      add(0,0,0,1,1, 0,0,0,0,1);             // first edge: no result
      for (int i = 0; i < 6; i++) add(0,0,0,0,1, 0,0,0,0,1);
      add(0,0,0,1,1, 7,1,0,0,1);
      add(0,0,0,0,1, 7,0,0,0,1);             // valid for one cycle only
      for (int i = 0; i < 5; i++) add(0,0,0,0,1, 7,0,0,0,1);
      add(0,0,0,1,1, 7,1,0,0,1);
      add(0,0,0,0,1, 7,0,0,0,1);

      // ---- consumer stalled: spacing 4 then 9 -> 4 held, overrun ----
      add(0,1,0,0,0, 7,0,0,0,1);
      add(0,0,0,1,0, 7,0,0,0,1);
      for (int i = 0; i < 3; i++) add(0,0,0,0,0, 7,0,0,0,1);
      add(0,0,0,1,0, 4,1,0,0,1);
      for (int i = 0; i < 8; i++) add(0,0,0,0,0, 4,1,0,0,1);
      add(0,0,0,1,0, 4,1,1,0,1);             // 9 dropped
      add(0,0,0,0,1, 4,0,1,0,1);             // drained, overrun sticky
      add(0,0,0,0,0, 4,0,1,0,1);
      add(0,1,0,0,0, 4,0,0,0,1);             // arm clears overrun

      // ---- capture coinciding with handshake: new value, valid stays, no overrun ----
      add(0,0,0,1,0, 4,0,0,0,1);
      add(0,0,0,0,0, 4,0,0,0,1);
      add(0,0,0,1,0, 2,1,0,0,1);
      add(0,0,0,0,0, 2,1,0,0,1);
      add(0,0,0,0,0, 2,1,0,0,1);
      add(0,0,0,1,1, 3,1,0,0,1);
      add(0,0,0,0,1, 3,0,0,0,1);

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].rst, vecs[i].arm, vecs[i].tv, vecs[i].pin, vecs[i].rdy);
         chk_all($sformatf("vec%0d", i), vecs[i].po, vecs[i].pv, vecs[i].ov,
                 vecs[i].to, vecs[i].bz);
      end

      // ---- timeout exactly 10 cycles after the edge ----
      step(0,1,10,0,1);
      chk_all("arm_t10", 3, 0, 0, 0, 1);
      step(0,0,0,1,1);
      for (int j = 1; j <= 9; j++) begin
         step(0,0,0,0,1);
         chk($sformatf("no_timeout_%0d", j), bus_if.timeout, 1'b0);
      end
      step(0,0,0,0,1);
      chk("timeout_set", bus_if.timeout, 1'b1);
      chk("timeout_busy", bus_if.busy, 1'b1);
      step(0,0,0,1,1);                      // back in WAIT_FIRST: this edge starts, no capture
      chk("after_timeout_no_capture", bus_if.period_valid, 1'b0);
      chk("timeout_sticky", bus_if.timeout, 1'b1);

      // ---- edge on the timeout cycle wins ----
      step(0,1,10,0,1);
      chk("rearm_clears_timeout", bus_if.timeout, 1'b0);
      step(0,0,0,1,1);
      for (int j = 0; j < 9; j++) step(0,0,0,0,1);
      step(0,0,0,1,1);
      chk_all("edge_at_limit", 10, 1, 0, 0, 1);

      // ---- pulse held high counts as one edge ----
      step(0,1,0,0,0);
      step(0,0,0,1,0);
      for (int j = 0; j < 10; j++) step(0,0,0,1,0);
      chk("held_high_no_capture", bus_if.period_valid, 1'b0);
      step(0,0,0,0,0);
      step(0,0,0,0,0);
      step(0,0,0,1,0);
      chk_all("held_high_period", 13, 1, 0, 0, 1);

      // ---- arm and edge in the same cycle: edge ignored ----
      step(0,0,0,0,0);
      step(0,1,0,1,0);
      chk_all("arm_with_edge", 13, 0, 0, 0, 1);
      step(0,0,0,0,0);
      step(0,0,0,1,0);                      // first counted edge: no result yet
      chk("arm_edge_ignored", bus_if.period_valid, 1'b0);

      // ---- reset in MEASURE with counter at 20 ----
      for (int j = 0; j < 19; j++) step(0,0,0,0,0);
      step(1,0,0,1,0);
      chk_all("rst_in_measure", 0, 0, 0, 0, 0);

      // ---- after reset, pulses produce nothing until armed ----
      step(0,0,0,0,1);
      step(0,0,0,1,1);
      step(0,0,0,0,1);
      step(0,0,0,0,1);
      step(0,0,0,1,1);
      chk_all("post_rst_idle", 0, 0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/period_capture.md
PERIOD_CAPTURE -- requirements
Module: period_capture

Interface
REQ-001: Ports SHALL be exactly as follows.
- clk  in  1  sole clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- arm  in  1  single-cycle start/restart of measurement.
- timeout_val  in  32  max period before timeout; sampled on arm; 0 disables timeout.
- pulse_in  in  1  measured pulse train, synchronous to clk.
- period_out  out  32  last captured period in clk cycles.
- period_valid  out  1  period_out holds an unconsumed result.
- period_ready  in  1  consumer accepts result.
- overrun  out  1  sticky: result dropped while period_valid pending.
- timeout  out  1  sticky: no edge within timeout_val cycles.
- busy  out  1  state != IDLE.
REQ-002: Single clock domain; reset synchronous and active-high; no asynchronous logic.

Function
REQ-003: Rising edge of pulse_in SHALL be detected as pulse_in==1 and a registered copy prev==0; prev SHALL update every cycle in every state.
REQ-004: States SHALL be IDLE, WAIT_FIRST and MEASURE.
REQ-005: IDLE SHALL ignore edges; arm moves to WAIT_FIRST.
REQ-006: arm in any state SHALL: go to WAIT_FIRST, latch timeout_val, clear counter, timeout, overrun and period_valid; a same-cycle edge is ignored (arm wins).
REQ-007: WAIT_FIRST edge SHALL move to MEASURE with counter <= 1; no capture.
REQ-008: In MEASURE without an edge, counter SHALL increment by 1 per cycle, saturating at 0xFFFF_FFFF.
REQ-009: MEASURE edge SHALL capture the current counter value (edge-to-edge distance in cycles) and reload counter <= 1; state stays MEASURE.
REQ-010: Edges spaced N cycles apart SHALL report N (e.g. pulse every 5 cycles -> 5).
REQ-011: In MEASURE, counter == latched timeout (nonzero) with no edge SHALL set timeout=1 and return to WAIT_FIRST; an edge in that same cycle wins and captures normally.
REQ-012: Capture SHALL load period_out and set period_valid on the next clock edge.
REQ-013: period_valid and period_out SHALL remain stable until the cycle where period_valid && period_ready, after which period_valid clears (unless REQ-014 applies).
REQ-014: Capture in the same cycle as a handshake SHALL load the new value and keep period_valid=1; no overrun.
REQ-015: Capture while period_valid=1 and period_ready=0 SHALL drop the new value, keep period_out unchanged, set overrun=1.
REQ-016: overrun and timeout SHALL clear only on arm or rst.
REQ-017: pulse_in held high SHALL yield only one edge; no further captures until it falls and rises again.
REQ-018: busy SHALL be 1 in WAIT_FIRST and MEASURE, 0 in IDLE.

Reset
REQ-019: rst=1 at a clock edge SHALL set state=IDLE, counter=0, prev=0, latched timeout=0, period_out=0, period_valid=0, overrun=0, timeout=0, busy=0, regardless of other inputs including arm.
REQ-020: rst mid-measurement SHALL abandon the measurement; no capture until a new arm.

Verification
REQ-021: rst, then pulses every 3 cycles without arm -> period_valid stays 0, busy=0.
REQ-022: arm with timeout_val=0, pulse_in single-cycle high every 7 cycles, period_ready=1 -> first edge gives no result; each later edge gives period_out=7, period_valid for 1 cycle.
REQ-023: arm, period_ready=0, edges at spacing 4 then 9 -> period_out=4 held, overrun=1; raise period_ready -> valid clears; arm -> overrun=0.
REQ-024: arm with timeout_val=10, one edge then none -> timeout=1 exactly 10 cycles after that edge, state WAIT_FIRST; repeat with edge exactly 10 cycles later -> period_out=10, timeout=0.
REQ-025: arm and edge in same cycle -> edge ignored, state WAIT_FIRST; rst asserted in MEASURE with counter=20 -> all outputs 0 next cycle.
